reset_gen: RTL and testbench

Upstream reset-request generator: merges a bouncy active-low push-button, the PLL lock indicator and a software reset request into one clean, stretched, glitch-free active-low reset request. `rst_out_n` drives the `arst_n` input of the per-domain reset synchronizers. It also records the cause of the most recent reset for status readback.

---
 rtl/reset_gen.sv | 180 ++++++++++++++++++
 tb/tb_reset_gen.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/reset_gen.sv
// Merges push-button, PLL lock and software request into one stretched active-low reset request.
// Optional watchdog source is enabled by defining RESET_GEN_WDT_EN.
module reset_gen #(
    parameter int unsigned DEBOUNCE_CYCLES    = 500000,
    parameter int unsigned LOCK_STABLE_CYCLES = 256,
    parameter int unsigned HOLD_CYCLES        = 1024,
    parameter int unsigned WDT_CYCLES         = 1 << 24
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       btn_n,
    input  logic       pll_locked,
    input  logic       sw_rst_req,
    input  logic       wdt_kick,
    output logic       rst_out_n,
    output logic       busy,
    output logic [2:0] cause
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int LK_W = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int HD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [2:0] CAUSE_BTN = 3'b001;
    localparam logic [2:0] CAUSE_PLL = 3'b010;
    localparam logic [2:0] CAUSE_SW  = 3'b011;
    localparam logic [2:0] CAUSE_WDT = 3'b100;

    typedef enum logic [1:0] {
        ASSERT    = 2'd0,
        WAIT_LOCK = 2'd1,
        HOLD      = 2'd2,
        RUN       = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [2:0]      cause_nxt;
    logic [LK_W-1:0] lock_cnt, lock_nxt;
    logic [HD_W-1:0] hold_cnt, hold_nxt;

    logic            btn_meta, btn_sync;
    logic            pll_meta, pll_sync;
    logic            btn_db;
    logic [DB_W-1:0] db_cnt;
    logic            wdt_hit;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            btn_meta <= 1'b1;
            btn_sync <= 1'b1;
            pll_meta <= 1'b0;
            pll_sync <= 1'b0;
        end else begin
            btn_meta <= btn_n;
            btn_sync <= btn_meta;
            pll_meta <= pll_locked;
            pll_sync <= pll_meta;
        end
    end

    // Accept a new button level only after it has differed for DEBOUNCE_CYCLES in a row.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            db_cnt <= '0;
            btn_db <= 1'b1;
        end else if (btn_sync == btn_db) begin
            db_cnt <= '0;
        end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_cnt <= '0;
            btn_db <= btn_sync;
        end else begin
            db_cnt <= db_cnt + DB_W'(1);
        end
    end

`ifdef RESET_GEN_WDT_EN
    localparam int WD_W = $clog2(WDT_CYCLES + 1);
    logic [WD_W-1:0] wdt_cnt;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wdt_cnt <= '0;
        end else if (state != RUN || wdt_kick) begin
            wdt_cnt <= '0;
        end else if (wdt_cnt != WD_W'(WDT_CYCLES)) begin
            wdt_cnt <= wdt_cnt + WD_W'(1);
        end
    end

    // A kick on the expiry cycle wins.
    assign wdt_hit = (state == RUN) && !wdt_kick && (wdt_cnt == WD_W'(WDT_CYCLES - 1));
`else
    logic unused_wdt_kick;
    assign unused_wdt_kick = wdt_kick;
    assign wdt_hit         = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        cause_nxt = cause;
        lock_nxt  = lock_cnt;
        hold_nxt  = hold_cnt;
        case (state)
            ASSERT: begin
                lock_nxt = '0;
                hold_nxt = '0;
                if (btn_db) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
                hold_nxt = '0;
                if (!btn_db) begin
                    state_nxt = ASSERT;
                    cause_nxt = CAUSE_BTN;
                    lock_nxt  = '0;
                end else if (!pll_sync) begin
                    lock_nxt = '0;
                end else if (lock_cnt == LK_W'(LOCK_STABLE_CYCLES)) begin
                    state_nxt = HOLD;
                    lock_nxt  = '0;
                end else begin
                    lock_nxt = lock_cnt + LK_W'(1);
                end
            end
            HOLD: begin
                if (!btn_db) begin
                    state_nxt = ASSERT;
                    cause_nxt = CAUSE_BTN;
                    hold_nxt  = '0;
                end else if (!pll_sync) begin
                    state_nxt = WAIT_LOCK;
                    lock_nxt  = '0;
                    hold_nxt  = '0;
                end else if (hold_cnt == HD_W'(HOLD_CYCLES - 1)) begin
                    state_nxt = RUN;
                    hold_nxt  = hold_cnt + HD_W'(1);
                end else begin
                    hold_nxt = hold_cnt + HD_W'(1);
                end
            end
            RUN: begin
                // Source priority: button, PLL, software, watchdog.
                if (!btn_db) begin
                    state_nxt = ASSERT;
                    cause_nxt = CAUSE_BTN;
                end else if (!pll_sync) begin
                    state_nxt = ASSERT;
                    cause_nxt = CAUSE_PLL;
                end else if (sw_rst_req) begin
                    state_nxt = ASSERT;
                    cause_nxt = CAUSE_SW;
                end else if (wdt_hit) begin
                    state_nxt = ASSERT;
                    cause_nxt = CAUSE_WDT;
                end
            end
            default: begin
                state_nxt = ASSERT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state     <= ASSERT;
            lock_cnt  <= '0;
            hold_cnt  <= '0;
            cause     <= 3'b000;
            rst_out_n <= 1'b0;
            busy      <= 1'b1;
        end else begin
            state     <= state_nxt;
            lock_cnt  <= lock_nxt;
            hold_cnt  <= hold_nxt;
            cause     <= cause_nxt;
            rst_out_n <= (state_nxt == RUN);
            busy      <= (state_nxt != RUN);
        end
    end

endmodule

// File: tb/tb_reset_gen.sv
// Directed test of reset_gen with small timing parameters; watchdog steps run only when
// RESET_GEN_WDT_EN is defined, otherwise the bench confirms wdt_kick has no effect.
module tb_reset_gen;

    localparam int unsigned DB = 8;
    localparam int unsigned LK = 4;
    localparam int unsigned HD = 16;
    localparam int unsigned WD = 32;

    logic       clk = 1'b0;
    logic       arst_n;
    logic       btn_n;
    logic       pll_locked;
    logic       sw_rst_req;
    logic       wdt_kick;
    logic       rst_out_n;
    logic       busy;
    logic [2:0] cause;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic kick_auto = 1'b1;
    logic kick_man  = 1'b0;

    reset_gen #(
        .DEBOUNCE_CYCLES   (DB),
        .LOCK_STABLE_CYCLES(LK),
        .HOLD_CYCLES       (HD),
        .WDT_CYCLES        (WD)
    ) dut (
        .clk       (clk),
        .arst_n    (arst_n),
        .btn_n     (btn_n),
        .pll_locked(pll_locked),
        .sw_rst_req(sw_rst_req),
        .wdt_kick  (wdt_kick),
        .rst_out_n (rst_out_n),
        .busy      (busy),
        .cause     (cause)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock edge; inputs are set before it and outputs are looked at 1 time unit after it.
    task automatic tick();
        wdt_kick = (kick_auto && (cyc % 20 == 0)) || kick_man;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Edges until rst_out_n reaches level; returns limit if it never does.
    task automatic edges_until(input logic level, input int limit, output int n);
        n = 0;
        while (rst_out_n !== level && n < limit) begin
            tick();
            n++;
        end
    endtask

    initial begin
        int n;
        int lows;
        int fell;

        arst_n     = 1'b0;
        btn_n      = 1'b1;
        pll_locked = 1'b1;
        sw_rst_req = 1'b0;
        wdt_kick   = 1'b0;
        ticks(3);
        chk("reset_rst_out_n", rst_out_n, 0);
        chk("reset_busy", busy, 1);
        chk("reset_cause", cause, 0);

        // Power-on: 1 (leave ASSERT) + 2 (lock sync) + LK + HD edges.
        arst_n = 1'b1;
        edges_until(1'b1, 200, n);
        chk("por_latency", n, 1 + 2 + LK + HD);
        chk("por_busy", busy, 0);
        chk("por_cause", cause, 0);

        // Bounce shorter than DB never gets through.
        lows = 0;
        for (int i = 0; i < 60; i++) begin
            btn_n = ((i / 3) % 2) == 1;
            tick();
            if (!rst_out_n) lows++;
        end
        btn_n = 1'b1;
        ticks(4);
        chk("bounce_no_reset", lows, 0);

        // Held press: falls on the 11th edge counting the first low sample as edge 1.
        btn_n = 1'b0;
        fell = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (!rst_out_n && fell == 0) fell = i;
        end
        chk("btn_latency", fell, 2 + DB + 1);
        chk("btn_cause", cause, 1);
        btn_n = 1'b1;
        edges_until(1'b1, 200, n);
        chk("btn_recover", rst_out_n, 1);

        // Software request in RUN: low on the sampling edge; low time is 1 + LK + HD plus
        // the WAIT_LOCK->HOLD move edge.
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        chk("sw_rst_low", rst_out_n, 0);
        chk("sw_busy", busy, 1);
        chk("sw_cause", cause, 3);
        edges_until(1'b1, 200, n);
        chk("sw_low_time", n, 1 + LK + HD + 1);

        // PLL loss in RUN reaches rst_out_n on the third edge.
        pll_locked = 1'b0;
        ticks(2);
        chk("pll_drop_edge2", rst_out_n, 1);
        tick();
        chk("pll_drop_edge3", rst_out_n, 0);
        chk("pll_cause", cause, 2);
        pll_locked = 1'b1;
        // HOLD is entered on edge 10 after the drop; a software pulse at edge 18 is ignored.
        ticks(14);
        chk("hold_busy", busy, 1);
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        chk("sw_in_hold_cause", cause, 2);
        edges_until(1'b1, 200, n);
        chk("sw_in_hold_no_effect", n, 8);

        // One-cycle lock glitch in HOLD restarts lock qualification:
        // 2 sync + 1 detect + LK lock + HD hold edges after relock.
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        ticks(10);
        pll_locked = 1'b0;
        tick();
        pll_locked = 1'b1;
        edges_until(1'b1, 200, n);
        chk("pll_glitch_relock", n, 2 + 1 + LK + HD);
        chk("pll_glitch_cause", cause, 3);

        // Button and software on the same cycle: button wins.
        btn_n = 1'b0;
        ticks(2 + DB);
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        chk("simul_low", rst_out_n, 0);
        chk("simul_cause", cause, 1);
        btn_n = 1'b1;
        edges_until(1'b1, 200, n);
        chk("simul_recover", rst_out_n, 1);

`ifdef RESET_GEN_WDT_EN
        lows = 0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (!rst_out_n) lows++;
        end
        chk("wdt_kicked_no_reset", lows, 0);

        kick_auto = 1'b0;
        kick_man  = 1'b1;
        tick();
        kick_man = 1'b0;
        edges_until(1'b0, 200, n);
        chk("wdt_expire", n, WD);
        chk("wdt_cause", cause, 4);
        edges_until(1'b1, 200, n);

        kick_man = 1'b1;
        tick();
        kick_man = 1'b0;
        ticks(WD - 1);
        kick_man = 1'b1;
        tick();
        kick_man = 1'b0;
        chk("wdt_kick_on_expiry", rst_out_n, 1);
        ticks(10);
        chk("wdt_kick_on_expiry_later", rst_out_n, 1);
        kick_auto = 1'b1;
`else
        kick_auto = 1'b0;
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!rst_out_n) lows++;
        end
        chk("no_wdt_no_reset", lows, 0);
        chk("no_wdt_cause", cause, 1);
        kick_auto = 1'b1;
`endif

        // arst_n mid-HOLD takes effect without a clock edge.
        sw_rst_req = 1'b1;
        tick();
        sw_rst_req = 1'b0;
        ticks(10);
        #2;
        arst_n = 1'b0;
        #1;
        chk("arst_rst_out_n", rst_out_n, 0);
        chk("arst_busy", busy, 1);
        chk("arst_cause", cause, 0);
        tick();
        arst_n = 1'b1;
        edges_until(1'b1, 200, n);
        chk("arst_por_latency", n, 1 + 2 + LK + HD);
        chk("arst_por_cause", cause, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
